led_scroll_renderer: RTL

LED_SCROLL_RENDERER -- requirements
Module: led_scroll_renderer

---
 rtl/led_scroll_renderer_pkg.sv | 87 ++++++++
 rtl/led_scroll_renderer_font_rom.sv | 21 ++
 rtl/led_scroll_renderer.sv | 88 ++++++++
 3 files changed

// File: rtl/led_scroll_renderer_pkg.sv
// Shared constants and the 4x8 glyph table for the scrolling LED renderer.
// Glyph words hold column 0 in the top byte; bit 0 of each byte is the top row.
package led_scroll_renderer_pkg;

    localparam int FONT_W = 4;
    localparam int FONT_H = 8;
    localparam logic [7:0] FONT_FIRST = 8'h20;
    localparam logic [7:0] FONT_LAST = 8'h5F;
    localparam int NUM_COLS = 8;
    localparam int SCAN_DIV_DEFAULT = 1000;

    function automatic logic [FONT_H-1:0] font_lookup(input logic [7:0] code, input logic [1:0] col);
        logic [FONT_W*FONT_H-1:0] glyph;
        glyph = '0;
        if (code >= FONT_FIRST && code <= FONT_LAST) begin
            case (code)
                8'h20: glyph = 32'h00000000;
                8'h21: glyph = 32'h005F0000;
                8'h22: glyph = 32'h07000700;
                8'h23: glyph = 32'h147F147F;
                8'h24: glyph = 32'h2E6B6B3A;
                8'h25: glyph = 32'h63180C63;
                8'h26: glyph = 32'h36493650;
                8'h27: glyph = 32'h00070000;
                8'h28: glyph = 32'h003E4100;
                8'h29: glyph = 32'h00413E00;
                8'h2A: glyph = 32'h2A1C1C2A;
                8'h2B: glyph = 32'h083E0800;
                8'h2C: glyph = 32'h00806000;
                8'h2D: glyph = 32'h08080808;
                8'h2E: glyph = 32'h00606000;
                8'h2F: glyph = 32'h60180601;
                8'h30: glyph = 32'h3E51453E;
                8'h31: glyph = 32'h00427F40;
                8'h32: glyph = 32'h62514946;
                8'h33: glyph = 32'h22494936;
                8'h34: glyph = 32'h18147F10;
                8'h35: glyph = 32'h27454539;
                8'h36: glyph = 32'h3E494932;
                8'h37: glyph = 32'h01710907;
                8'h38: glyph = 32'h36494936;
                8'h39: glyph = 32'h2649493E;
                8'h3A: glyph = 32'h00360000;
                8'h3B: glyph = 32'h00563600;
                8'h3C: glyph = 32'h08142241;
                8'h3D: glyph = 32'h14141414;
                8'h3E: glyph = 32'h41221408;
                8'h3F: glyph = 32'h02510906;
                8'h40: glyph = 32'h3E415D4E;
                8'h41: glyph = 32'h7E09097E;
                8'h42: glyph = 32'h7F494936;
                8'h43: glyph = 32'h3E414122;
                8'h44: glyph = 32'h7F41413E;
                8'h45: glyph = 32'h7F494941;
                8'h46: glyph = 32'h7F090901;
                8'h47: glyph = 32'h3E41497A;
                8'h48: glyph = 32'h7F08087F;
                8'h49: glyph = 32'h417F4100;
                8'h4A: glyph = 32'h2040403F;
                8'h4B: glyph = 32'h7F081463;
                8'h4C: glyph = 32'h7F404040;
                8'h4D: glyph = 32'h7F06067F;
                8'h4E: glyph = 32'h7F0C307F;
                8'h4F: glyph = 32'h3E41413E;
                8'h50: glyph = 32'h7F090906;
                8'h51: glyph = 32'h3E41617E;
                8'h52: glyph = 32'h7F091966;
                8'h53: glyph = 32'h26494932;
                8'h54: glyph = 32'h017F0101;
                8'h55: glyph = 32'h3F40403F;
                8'h56: glyph = 32'h1F60601F;
                8'h57: glyph = 32'h7F30307F;
                8'h58: glyph = 32'h631C1C63;
                8'h59: glyph = 32'h07780807;
                8'h5A: glyph = 32'h61514943;
                8'h5B: glyph = 32'h007F4141;
                8'h5C: glyph = 32'h01061860;
                8'h5D: glyph = 32'h41417F00;
                8'h5E: glyph = 32'h02010200;
                8'h5F: glyph = 32'h40404040;
                default: glyph = '0;
            endcase
        end
        return glyph[(FONT_W - 1 - int'(col)) * FONT_H +: FONT_H];
    endfunction

endpackage

// File: rtl/led_scroll_renderer_font_rom.sv
// Registered glyph-column lookup; holds its last byte while no column is requested.
module font_rom
    import led_scroll_renderer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [7:0]        code,
    input  logic [1:0]        col,
    output logic [FONT_H-1:0] data
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            data <= '0;
        end else if (en) begin
            data <= font_lookup(code, col);
        end
    end

endmodule

// File: rtl/led_scroll_renderer.sv
// Scrolling LED column renderer: glyph columns shift into an 8-column buffer
// while a prescaled scanner drives one column at a time.
module led_scroll_renderer
    import led_scroll_renderer_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEFAULT,
    parameter int NUM_COLS = led_scroll_renderer_pkg::NUM_COLS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                write,
    input  logic [7:0]          char_in,
    input  logic [1:0]          column,
    output logic [NUM_COLS-1:0] col_sel,
    output logic [7:0]          row_data
);

    localparam int IDX_W = $clog2(NUM_COLS);
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

    logic [7:0]       rom_byte;
    logic             rom_valid;
    logic [7:0]       s1_byte;
    logic             s1_valid;
    logic [7:0]       disp_buf [NUM_COLS];
    logic [PRE_W-1:0] pre_cnt;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] next_idx;
    logic             scan_wrap;

    font_rom u_font_rom (
        .clk  (clk),
        .rst  (rst),
        .en   (write),
        .code (char_in),
        .col  (column),
        .data (rom_byte)
    );

    // The valid flag travels beside the ROM's registered read so a reset
    // anywhere in the pipe drops the column before it reaches the buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rom_valid <= 1'b0;
            s1_valid  <= 1'b0;
            s1_byte   <= '0;
        end else begin
            rom_valid <= write;
            s1_valid  <= rom_valid;
            s1_byte   <= rom_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                disp_buf[i] <= '0;
            end
        end else if (s1_valid) begin
            for (int i = 0; i < NUM_COLS - 1; i++) begin
                disp_buf[i] <= disp_buf[i+1];
            end
            disp_buf[NUM_COLS-1] <= s1_byte;
        end
    end

    assign scan_wrap = (pre_cnt == PRE_MAX);
    assign next_idx  = scan_idx + 1'b1;

    // row_data samples the buffer as it stood before any shift on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_cnt  <= '0;
            scan_idx <= '0;
            col_sel  <= NUM_COLS'(1);
            row_data <= '0;
        end else if (scan_wrap) begin
            pre_cnt  <= '0;
            scan_idx <= next_idx;
            col_sel  <= NUM_COLS'(1) << next_idx;
            row_data <= disp_buf[next_idx];
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

endmodule
